sobel_stream_engine: RTL and testbench

Parametrised streaming Sobel engine that replaces the per-window read/shift/calculate sequencing with a fully pipelined 3x3 operator fed by on-chip line buffers. It accepts one pixel per cycle in raster order over a valid/ready stream, computes horizontal and vertical gradients, and emits one result per interior pixel in a selectable output mode. It sits between the AHB read path (pixel source) and the AHB write path (result sink), under control of the frame controller.

---
 rtl/sobel_stream_engine_if.sv | 16 +
 rtl/sobel_stream_engine.sv | 166 ++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_engine_if.sv
// sobel_stream_engine_if: pixel-in / result-out stream handshake bundle
//   in_valid/in_ready/in_pixel       : raster-order pixel stream into the engine
//   out_valid/out_ready/out_pixel    : result stream out of the engine
//   out_last                         : marks the final result of a frame
//   slave  : engine side, master : source/sink side
interface sobel_stream_engine_if #(parameter int DATA_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pixel;
    logic              out_last;
    modport slave  (input in_valid, in_pixel, out_ready, output in_ready, out_valid, out_pixel, out_last);
    modport master (output in_valid, in_pixel, out_ready, input in_ready, out_valid, out_pixel, out_last);
endinterface

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: pipelined 3x3 Sobel operator fed by two line buffers
//   clk, n_rst          : clock, asynchronous active-low reset
//   i_start             : pulse, latches frame size, mode and threshold
//   i_cfg_width/height  : frame dimensions (width 3..MAX_WIDTH, height >= 3)
//   i_mode, i_thresh    : 0 magnitude, 1 threshold, 2 |gx|, 3 |gy|
//   bus                 : pixel input and result output streams
//   o_busy, o_frame_done, o_cfg_err : frame status
module sobel_stream_engine #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 640,
    parameter int DIM_W     = 12
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_start,
    input  logic [DIM_W-1:0]     i_cfg_width,
    input  logic [DIM_W-1:0]     i_cfg_height,
    input  logic [1:0]           i_mode,
    input  logic [DATA_W-1:0]    i_thresh,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_cfg_err,
    sobel_stream_engine_if.slave bus
);
    localparam int GW = DATA_W + 3;
    localparam int AW = $clog2(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                r_state, w_next;
    logic [DIM_W-1:0]      r_w_cfg, r_h_cfg, r_col, r_row;
    logic [1:0]            r_mode;
    logic [DATA_W-1:0]     r_thresh;
    logic [DATA_W-1:0]     r_lb0 [MAX_WIDTH];
    logic [DATA_W-1:0]     r_lb1 [MAX_WIDTH];
    logic [DATA_W-1:0]     r_win [3][3];
    logic [DATA_W-1:0]     w_nwin [3][3];
    logic signed [GW-1:0]  r_gx, r_gy, w_gx, w_gy;
    logic                  r_v1, r_last1, r_ov, r_olast, r_done, r_err;
    logic [DATA_W-1:0]     r_opix, w_res;
    logic                  w_en, w_acc, w_out_acc, w_legal, w_col_end, w_row_end, w_done, w_err;
    logic [AW-1:0]         w_ci;
    logic [GW-1:0]         w_ax, w_ay, w_mag;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] x);
        return $signed({3'b000, x});
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] v);
        return |v[GW-1:DATA_W] ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

    // A single enable stalls the whole pipeline while a result waits
    assign w_en       = ~r_ov | bus.out_ready;
    assign bus.in_ready = w_en & (r_state == RUN);
    assign w_acc      = bus.in_valid & bus.in_ready;
    assign w_out_acc  = r_ov & bus.out_ready;
    assign w_legal    = (i_cfg_width >= DIM_W'(3)) && (i_cfg_width <= DIM_W'(MAX_WIDTH)) && (i_cfg_height >= DIM_W'(3));
    assign w_col_end  = r_col == r_w_cfg - DIM_W'(1);
    assign w_row_end  = r_row == r_h_cfg - DIM_W'(1);
    assign w_ci       = r_col[AW-1:0];

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE:  begin
                w_next = (i_start && w_legal) ? RUN : IDLE;
                w_err  = i_start & ~w_legal;
            end
            RUN:   w_next = (w_acc && w_col_end && w_row_end) ? DRAIN : RUN;
            DRAIN: begin
                w_next = (w_out_acc && r_olast) ? IDLE : DRAIN;
                w_done = w_out_acc & r_olast;
            end
            default: w_next = IDLE;
        endcase
    end

    // Window shifts left; new right column is rows r-2, r-1, r from the line buffers and input
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_nwin[i][0] = r_win[i][1];
            w_nwin[i][1] = r_win[i][2];
        end
        w_nwin[0][2] = r_lb1[w_ci];
        w_nwin[1][2] = r_lb0[w_ci];
        w_nwin[2][2] = bus.in_pixel;
    end

    assign w_gx = ext(w_nwin[0][2]) + (ext(w_nwin[1][2]) <<< 1) + ext(w_nwin[2][2])
                - ext(w_nwin[0][0]) - (ext(w_nwin[1][0]) <<< 1) - ext(w_nwin[2][0]);
    assign w_gy = ext(w_nwin[2][0]) + (ext(w_nwin[2][1]) <<< 1) + ext(w_nwin[2][2])
                - ext(w_nwin[0][0]) - (ext(w_nwin[0][1]) <<< 1) - ext(w_nwin[0][2]);

    assign w_ax  = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    assign w_ay  = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    assign w_mag = w_ax + w_ay;
    assign w_res = (r_mode == 2'd0) ? sat(w_mag) :
                   (r_mode == 2'd1) ? ((w_mag >= {3'b000, r_thresh}) ? {DATA_W{1'b1}} : '0) :
                   (r_mode == 2'd2) ? sat(w_ax) : sat(w_ay);

    // Line buffers hold pixel data only; stale contents are masked by border suppression
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[w_ci] <= r_lb0[w_ci];
            r_lb0[w_ci] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_w_cfg  <= '0;
            r_h_cfg  <= '0;
            r_mode   <= '0;
            r_thresh <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_win    <= '{default: '0};
            r_gx     <= '0;
            r_gy     <= '0;
            r_v1     <= 1'b0;
            r_last1  <= 1'b0;
            r_ov     <= 1'b0;
            r_opix   <= '0;
            r_olast  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
            r_err   <= w_err;
            if (r_state == IDLE && i_start && w_legal) begin
                r_w_cfg  <= i_cfg_width;
                r_h_cfg  <= i_cfg_height;
                r_mode   <= i_mode;
                r_thresh <= i_thresh;
                r_col    <= '0;
                r_row    <= '0;
            end
            if (w_acc) begin
                r_col <= w_col_end ? '0 : r_col + DIM_W'(1);
                r_row <= w_col_end ? (w_row_end ? '0 : r_row + DIM_W'(1)) : r_row;
                r_win <= w_nwin;
                r_gx  <= w_gx;
                r_gy  <= w_gy;
            end
            if (w_en) begin
                r_v1    <= w_acc && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));
                r_last1 <= w_acc & w_col_end & w_row_end;
                r_ov    <= r_v1;
                r_opix  <= w_res;
                r_olast <= r_last1;
            end
        end
    end

    assign bus.out_valid = r_ov;
    assign bus.out_pixel = r_opix;
    assign bus.out_last  = r_olast;
    assign o_busy        = r_state != IDLE;
    assign o_frame_done  = r_done;
    assign o_cfg_err     = r_err;
endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: directed checks of the streaming Sobel engine
module tb_sobel_stream_engine;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        start = 1'b0;
    logic [11:0] cfg_w = '0, cfg_h = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  thresh = '0;
    logic        busy, frame_done, cfg_err;
    int          errors = 0, checks = 0;
    logic [7:0]  img [16][16];
    int          exp_q [$];

    sobel_stream_engine_if #(.DATA_W(8)) bus ();

    sobel_stream_engine #(.DATA_W(8), .MAX_WIDTH(640), .DIM_W(12)) dut (
        .clk(clk), .n_rst(n_rst), .i_start(start), .i_cfg_width(cfg_w), .i_cfg_height(cfg_h),
        .i_mode(mode), .i_thresh(thresh), .o_busy(busy), .o_frame_done(frame_done),
        .o_cfg_err(cfg_err), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model(int r, int c, int md, int th);
        int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        int gx = 0, gy = 0, ax, ay, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                gx += kx[i][j] * int'(img[r-1+i][c-1+j]);
                gy += ky[i][j] * int'(img[r-1+i][c-1+j]);
            end
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        mag = ax + ay;
        return md == 0 ? (mag > 255 ? 255 : mag) :
               md == 1 ? (mag >= th ? 255 : 0) :
               md == 2 ? (ax > 255 ? 255 : ax) : (ay > 255 ? 255 : ay);
    endfunction

    task automatic fill_ramp(input int step);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'(step * c);
    endtask

    task automatic do_start(input int w, input int h, input logic [1:0] md, input logic [7:0] th);
        @(negedge clk);
        start = 1'b1; cfg_w = 12'(w); cfg_h = 12'(h); mode = md; thresh = th;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
        check("cfg_err_legal", cfg_err, 0);
    endtask

    task automatic run_frame(input int w, input int h, input bit rnd);
        int idx = 0, got = 0, cyc = 0;
        bit done_exp = 0, done_seen = 0, stalled = 0;
        logic [7:0] hp = '0;
        logic hl = 1'b0;
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            check("frame_done", frame_done, done_exp);
            if (done_exp) begin
                check("busy_fall", busy, 0);
                done_seen = 1;
            end else begin
                if (stalled) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_pixel", bus.out_pixel, hp);
                    check("stall_last", bus.out_last, hl);
                end
                bus.in_valid = idx < w * h;
                if (idx < w * h) bus.in_pixel = img[idx / w][idx % w];
                bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                stalled = bus.out_valid && !bus.out_ready;
                hp = bus.out_pixel;
                hl = bus.out_last;
                if (bus.in_valid && bus.in_ready) idx++;
                if (bus.out_valid && bus.out_ready) begin
                    check("pixel", bus.out_pixel, got < exp_q.size() ? exp_q[got] : 32'hFFFF_FFFF);
                    check("last", bus.out_last, got == exp_q.size() - 1);
                    if (bus.out_last) done_exp = 1;
                    got++;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("frame_timeout", done_seen, 1);
        check("result_count", got, exp_q.size());
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.out_ready = 1'b1;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pixel", bus.out_pixel, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        fill_ramp(10);
        exp_q = {};
        repeat (6) exp_q.push_back(80);
        do_start(5, 4, 2'd0, 8'd0);
        run_frame(5, 4, 0);

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'd200;
        exp_q = {};
        repeat (36) exp_q.push_back(0);
        do_start(8, 8, 2'd0, 8'd0);
        run_frame(8, 8, 0);

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r][c] = c < 3 ? 8'd0 : 8'd255;
        exp_q = {};
        repeat (3) exp_q = {exp_q, 0, 255, 255, 0};
        do_start(6, 5, 2'd0, 8'd0);
        run_frame(6, 5, 0);
        do_start(6, 5, 2'd2, 8'd0);
        run_frame(6, 5, 0);
        exp_q = {};
        repeat (12) exp_q.push_back(0);
        do_start(6, 5, 2'd3, 8'd0);
        run_frame(6, 5, 0);

        fill_ramp(10);
        exp_q = {};
        repeat (8) exp_q.push_back(0);
        do_start(6, 4, 2'd1, 8'd100);
        run_frame(6, 4, 0);
        fill_ramp(30);
        exp_q = {};
        repeat (8) exp_q.push_back(255);
        do_start(6, 4, 2'd1, 8'd100);
        run_frame(6, 4, 0);

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
        exp_q = {};
        for (int r = 1; r < 15; r++)
            for (int c = 1; c < 15; c++) exp_q.push_back(model(r, c, 0, 0));
        do_start(16, 16, 2'd0, 8'd0);
        run_frame(16, 16, 1);
        exp_q = {};
        for (int r = 1; r < 7; r++)
            for (int c = 1; c < 7; c++) exp_q.push_back(model(r, c, 3, 0));
        do_start(8, 8, 2'd3, 8'd0);
        run_frame(8, 8, 1);

        @(negedge clk);
        start = 1'b1; cfg_w = 12'd2; cfg_h = 12'd4;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 0);
        check("cfg_err_busy2", busy, 0);

        do_start(8, 8, 2'd0, 8'd0);
        repeat (30) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_pixel", bus.out_pixel, 0);
        check("midrst_out_last", bus.out_last, 0);
        @(negedge clk);
        n_rst = 1'b1;
        fill_ramp(10);
        exp_q = {};
        repeat (6) exp_q.push_back(80);
        do_start(5, 4, 2'd0, 8'd0);
        run_frame(5, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
